fp_add_seq: RTL and testbench

Sequential single-precision (IEEE-754 layout) floating-point adder placed directly downstream of the FP multiplier. It consumes the multiplier's 32-bit result bus, together with a second operand (typically the accumulator value), to form the add half of a multiply-accumulate path. It uses the same start/done handshake as the multiplier and does alignment and normalisation one bit per cycle to keep the datapath small. Zero is supported; denormals, NaN and Inf inputs are not. Rounding is truncation; overflow saturates to +/-Inf.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_add_ctrl.sv | 76 +++++++
 rtl/fp_add_dp.sv | 138 +++++++++++++
 rtl/fp_add_seq.sv | 65 ++++++
 tb/tb_fp_add_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point blocks.
// Holds the IEEE-754 single-precision field widths and bias, the state
// encoding of the adder FSM, and a packed view of a 32-bit FP word.
package fp_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;   // fraction plus hidden bit

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_WRITE
  } add_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/fp_add_ctrl.sv
// Control FSM of the sequential FP adder.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : startAdd handshake input
//   cnt_zero, my_zero    : alignment status, evaluated on the values being
//                          written this cycle (post-load / post-shift)
//   s_zero, s24, s23     : current sum register status for normalisation
//   er_max, er_min       : result exponent is 254 / 1 (next step saturates /
//                          flushes)
//   ld, aln, add, nrm, wr: registered one-hot strobes, high while in
//                          Load / Align / Add / Norm / Write
//   done                 : registered, high only while in Idle
module fp_add_ctrl
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cnt_zero,
  input  logic my_zero,
  input  logic s_zero,
  input  logic s24,
  input  logic s23,
  input  logic er_max,
  input  logic er_min,
  output logic ld,
  output logic aln,
  output logic add,
  output logic nrm,
  output logic wr,
  output logic done
);

  add_state_t state, nxt;

  // Align is only entered (and only kept) while the value just shifted in
  // still needs another shift, so every Align cycle performs a shift.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = start ? ST_INIT : ST_IDLE;
      ST_INIT:  nxt = start ? ST_INIT : ST_LOAD;
      ST_LOAD,
      ST_ALIGN: nxt = (cnt_zero || my_zero) ? ST_ADD : ST_ALIGN;
      ST_ADD:   nxt = ST_NORM;
      ST_NORM: begin
        if (s_zero)    nxt = ST_WRITE;
        else if (s24)  nxt = er_max ? ST_WRITE : ST_NORM;
        else if (!s23) nxt = er_min ? ST_WRITE : ST_NORM;
        else           nxt = ST_WRITE;
      end
      ST_WRITE: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ld    <= 1'b0;
      aln   <= 1'b0;
      add   <= 1'b0;
      nrm   <= 1'b0;
      wr    <= 1'b0;
      done  <= 1'b1;
    end else begin
      state <= nxt;
      ld    <= (nxt == ST_LOAD);
      aln   <= (nxt == ST_ALIGN);
      add   <= (nxt == ST_ADD);
      nrm   <= (nxt == ST_NORM);
      wr    <= (nxt == ST_WRITE);
      done  <= (nxt == ST_IDLE);
    end
  end

endmodule

// File: rtl/fp_add_dp.sv
// Datapath of the sequential FP adder: operand unpack, one-bit-per-cycle
// alignment, 25-bit add/subtract, one-bit-per-cycle normalisation with
// truncation, saturation to Inf and underflow flush, and the result register.
//   clk, rst                 : clock, asynchronous active-high reset
//   ld, aln, add, nrm, wr    : strobes from the controller
//   abus, bbus               : operands (stable from Init through Load)
//   sum_bus                  : registered result
//   cnt_zero, my_zero        : status of the cnt / My values being written
//   s_zero, s24, s23         : status of the current sum register
//   er_max, er_min           : result exponent equals 254 / 1
module fp_add_dp
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              aln,
  input  logic              add,
  input  logic              nrm,
  input  logic              wr,
  input  logic [31:0]       abus,
  input  logic [31:0]       bbus,
  output logic [31:0]       sum_bus,
  output logic              cnt_zero,
  output logic              my_zero,
  output logic              s_zero,
  output logic              s24,
  output logic              s23,
  output logic              er_max,
  output logic              er_min
);

  function automatic logic [MANT_W-1:0] unpack_mant(input fp_word_t w);
    return (w.exp == '0) ? '0 : {1'b1, w.frac};
  endfunction

  function automatic fp_word_t sat_inf(input logic sign);
    fp_word_t r;
    r.sign = sign;
    r.exp  = '1;
    r.frac = '0;
    return r;
  endfunction

  fp_word_t a_w, b_w, x_w, y_w, inf_w;

  logic              sx, sr, eq_sgn;
  logic [EXP_W-1:0]  ex, er, cnt, cnt_d;
  logic [MANT_W-1:0] mx, my, my_d;
  logic [MANT_W:0]   s;

  assign a_w = abus;
  assign b_w = bbus;

  // Magnitude compare on bits 30:0; A is taken as X on a tie.
  assign x_w = (abus[30:0] >= bbus[30:0]) ? a_w : b_w;
  assign y_w = (abus[30:0] >= bbus[30:0]) ? b_w : a_w;

  assign inf_w = sat_inf(sr);

  // Next cnt / My: the freshly unpacked values in Load, the shifted values
  // in Align. The controller decides on these so no idle Align cycle exists.
  always_comb begin
    if (ld) begin
      cnt_d = x_w.exp - y_w.exp;
      my_d  = unpack_mant(y_w);
    end else begin
      cnt_d = cnt - 8'd1;
      my_d  = my >> 1;
    end
  end

  assign cnt_zero = (cnt_d == '0);
  assign my_zero  = (my_d == '0);
  assign s_zero   = (s == '0);
  assign s24      = s[MANT_W];
  assign s23      = s[MANT_W-1];
  assign er_max   = (er == 8'd254);
  assign er_min   = (er == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx      <= 1'b0;
      ex      <= '0;
      eq_sgn  <= 1'b0;
      mx      <= '0;
      my      <= '0;
      cnt     <= '0;
      s       <= '0;
      sr      <= 1'b0;
      er      <= '0;
      sum_bus <= '0;
    end else begin
      // Load
      if (ld) begin
        sx     <= x_w.sign;
        ex     <= x_w.exp;
        eq_sgn <= (a_w.sign == b_w.sign);
        mx     <= unpack_mant(x_w);
        my     <= my_d;
        cnt    <= cnt_d;
      end
      // Align
      if (aln) begin
        my  <= my_d;
        cnt <= cnt_d;
      end
      // Add: X has the larger magnitude, so the difference never goes negative
      if (add) begin
        s  <= eq_sgn ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        er <= ex;
        sr <= sx;
      end
      // Norm: forced results are encoded straight into sr/er/s so Write
      // only has to pack the fields
      if (nrm) begin
        if (s_zero) begin
          {sr, er} <= '0;
        end else if (s24) begin
          if (er_max) {sr, er, s} <= {inf_w.sign, inf_w.exp, 2'b00, inf_w.frac};
          else begin
            s  <= s >> 1;
            er <= er + 8'd1;
          end
        end else if (!s23) begin
          if (er_min) {sr, er, s} <= '0;
          else begin
            s  <= s << 1;
            er <= er - 8'd1;
          end
        end
      end
      // Write
      if (wr) sum_bus <= {sr, er, s[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Sequential single-precision FP adder (add half of a multiply-accumulate).
// Zero supported; denormal/NaN/Inf inputs unsupported; truncation rounding;
// overflow saturates to +/-Inf.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   startAdd : start handshake (pulse or level, same as the multiplier)
//   Abus     : operand A (normally the multiplier result)
//   Bbus     : operand B (normally the accumulator)
//   SumBus   : registered result, held until the next Write
//   doneAdd  : high only while idle
module fp_add_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startAdd,
  input  logic [31:0] Abus,
  input  logic [31:0] Bbus,
  output logic [31:0] SumBus,
  output logic        doneAdd
);

  logic ld, aln, add, nrm, wr;
  logic cnt_zero, my_zero, s_zero, s24, s23, er_max, er_min;

  fp_add_ctrl u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (startAdd),
    .cnt_zero (cnt_zero),
    .my_zero  (my_zero),
    .s_zero   (s_zero),
    .s24      (s24),
    .s23      (s23),
    .er_max   (er_max),
    .er_min   (er_min),
    .ld       (ld),
    .aln      (aln),
    .add      (add),
    .nrm      (nrm),
    .wr       (wr),
    .done     (doneAdd)
  );

  fp_add_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .aln      (aln),
    .add      (add),
    .nrm      (nrm),
    .wr       (wr),
    .abus     (Abus),
    .bbus     (Bbus),
    .sum_bus  (SumBus),
    .cnt_zero (cnt_zero),
    .my_zero  (my_zero),
    .s_zero   (s_zero),
    .s24      (s24),
    .s23      (s23),
    .er_max   (er_max),
    .er_min   (er_min)
  );

endmodule

// File: tb/tb_fp_add_seq.sv
// Testbench for fp_add_seq: directed spec vectors, handshake and reset
// scenarios, and randomized operations checked against a closed-form model
// of the truncating sequential adder (result and Load-to-Idle latency).
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        startAdd;
  logic [31:0] Abus, Bbus;
  logic [31:0] SumBus;
  logic        doneAdd;

  int tests = 0;
  int fails = 0;

  fp_add_seq dut (
    .clk      (clk),
    .rst      (rst),
    .startAdd (startAdd),
    .Abus     (Abus),
    .Bbus     (Bbus),
    .SumBus   (SumBus),
    .doneAdd  (doneAdd)
  );

  always #5 clk = ~clk;

  // Reference: align by truncating the smaller mantissa, add/subtract, then
  // normalise from the leading-one position. lat counts negedges from the
  // cycle startAdd is dropped until doneAdd is seen (Init->Load edge + 3+a+n).
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    logic [31:0] x, y;
    logic [22:0] fr;
    int ex, ey, d, acyc, n, p, k;
    longint mx, my, s;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
    my = (ey == 0) ? 64'd0 : longint'({1'b1, y[22:0]});
    d  = ex - ey;
    acyc = 0;
    if (d > 0 && my != 0) begin
      acyc = (d < 24) ? d : 24;
      my   = (d >= 24) ? 64'd0 : (my >> d);
    end
    s = (x[31] == y[31]) ? (mx + my) : (mx - my);
    p = -1;
    for (int i = 24; i >= 0; i--) if (p < 0 && s[i]) p = i;
    if (p < 0) begin
      r = 32'h0; n = 1;
    end else if (p == 24) begin
      if (ex + 1 >= 255) begin
        r = {x[31], 8'hFF, 23'h0}; n = 1;
      end else begin
        fr = 23'(s >> 1);
        r = {x[31], 8'(ex + 1), fr}; n = 2;
      end
    end else if (p == 23) begin
      fr = 23'(s);
      r = {x[31], 8'(ex), fr}; n = 1;
    end else begin
      k = 23 - p;
      if (ex - k <= 0) begin
        r = 32'h0; n = ex;
      end else begin
        fr = 23'(s << k);
        r = {x[31], 8'(ex - k), fr}; n = k + 1;
      end
    end
    lat = 4 + acyc + n;
  endfunction

  // Runs one operation with a single-cycle start pulse. With noise set,
  // startAdd is toggled randomly while the adder is busy (must be ignored).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output logic [31:0] sum, output int cyc);
    @(negedge clk);
    Abus = a; Bbus = b; startAdd = 1'b1;
    @(negedge clk);
    startAdd = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (noise) startAdd = (cyc <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end while (!doneAdd && cyc < 200);
    startAdd = 1'b0;
    sum = SumBus;
  endtask

  task automatic test_reset;
    rst = 1'b1; startAdd = 1'b0; Abus = 32'h0; Bbus = 32'h0;
    #1;
    tests++;
    if (SumBus !== 32'h0) begin fails++; $display("FAIL reset_sum got=%h want=00000000", SumBus); end
    tests++;
    if (doneAdd !== 1'b1) begin fails++; $display("FAIL reset_done got=%b want=1", doneAdd); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (doneAdd !== 1'b1) begin fails++; $display("FAIL idle_done got=%b want=1", doneAdd); end
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h00000000, 32'h3F800000, 32'h7F7FFFFF};
    logic [31:0] vb [6] = '{32'h3F800000, 32'hBF400000, 32'hBFC00000, 32'h00000000, 32'h30800000, 32'h7F7FFFFF};
    logic [31:0] vr [6] = '{32'h40000000, 32'h3E800000, 32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000};
    int          vl [6] = '{6, 8, 5, 5, 29, 5};
    logic [31:0] sum;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 1'b0, sum, cyc);
      tests++;
      if (sum !== vr[i]) begin
        fails++; $display("FAIL directed_sum %h+%h got=%h want=%h", va[i], vb[i], sum, vr[i]);
      end
      tests++;
      if (cyc != vl[i]) begin
        fails++; $display("FAIL directed_latency %h+%h got=%0d want=%0d", va[i], vb[i], cyc, vl[i]);
      end
    end
  endtask

  task automatic test_handshake;
    int cyc;
    @(negedge clk);
    Abus = 32'h12345678; Bbus = 32'h40490FDB; startAdd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (doneAdd !== 1'b0) begin fails++; $display("FAIL init_hold_done got=%b want=0", doneAdd); end
      if (i == 0) begin Abus = 32'h41200000; Bbus = 32'hC2C80000; end
      else        begin Abus = 32'h3F800000; Bbus = 32'hBF400000; end
    end
    @(negedge clk);
    startAdd = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!doneAdd && cyc < 200);
    tests++;
    if (SumBus !== 32'h3E800000) begin fails++; $display("FAIL hold_start_sum got=%h want=3E800000", SumBus); end
    tests++;
    if (cyc != 8) begin fails++; $display("FAIL hold_start_latency got=%0d want=8", cyc); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] sum;
    int cyc;
    @(negedge clk);
    Abus = 32'h3F800000; Bbus = 32'h30800000; startAdd = 1'b1;
    @(negedge clk);
    startAdd = 1'b0;
    repeat (5) @(negedge clk);   // well inside the 24 Align cycles
    tests++;
    if (doneAdd !== 1'b0) begin fails++; $display("FAIL busy_before_reset got=%b want=0", doneAdd); end
    rst = 1'b1;
    #1;
    tests++;
    if (SumBus !== 32'h0) begin fails++; $display("FAIL mid_reset_sum got=%h want=00000000", SumBus); end
    tests++;
    if (doneAdd !== 1'b1) begin fails++; $display("FAIL mid_reset_done got=%b want=1", doneAdd); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    tests++;
    if (SumBus !== 32'h0) begin fails++; $display("FAIL no_partial_write got=%h want=00000000", SumBus); end
    run_op(32'h3F800000, 32'h3F800000, 1'b0, sum, cyc);
    tests++;
    if (sum !== 32'h40000000) begin fails++; $display("FAIL after_reset_sum got=%h want=40000000", sum); end
    tests++;
    if (cyc != 6) begin fails++; $display("FAIL after_reset_latency got=%0d want=6", cyc); end
  endtask

  function automatic logic [31:0] rnd_fp(input int e);
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  task automatic test_random;
    logic [31:0] a, b, sum, exp_sum;
    int cyc, exp_lat, ea, eb, mode;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 5);
      ea = $urandom_range(1, 254);
      a  = rnd_fp(ea);
      case (mode)
        0: begin
          eb = ea + $urandom_range(0, 60) - 30;
          if (eb < 1) eb = 1;
          if (eb > 254) eb = 254;
          b = rnd_fp(eb);
        end
        1: b = {~a[31], a[30:4], 4'($urandom)};
        2: begin
          b = 32'h0;
          if ($urandom_range(0, 1) == 1) begin b = a; a = {1'($urandom_range(0, 1)), 31'h0}; end
        end
        3: begin
          a = {1'b0, 8'($urandom_range(250, 254)), 23'($urandom)};
          b = {1'b0, 8'($urandom_range(250, 254)), 23'($urandom)};
          if ($urandom_range(0, 1) == 1) begin a[31] = 1'b1; b[31] = 1'b1; end
        end
        4: begin
          a = {1'b0, 8'($urandom_range(1, 3)), 23'($urandom)};
          b = {1'b1, 8'($urandom_range(1, 3)), 23'($urandom)};
        end
        default: b = rnd_fp($urandom_range(1, 254));
      endcase
      ref_add(a, b, exp_sum, exp_lat);
      run_op(a, b, 1'b1, sum, cyc);
      tests++;
      if (sum !== exp_sum || cyc != exp_lat) begin
        fails++;
        $display("FAIL random %h+%h got=%h/%0d want=%h/%0d", a, b, sum, cyc, exp_sum, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_handshake;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
